// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal shift register with parallel load,
// serial fill and a counted shift sequencer (shift/rotate, left/right).
// A single start runs N shifts autonomously and then pulses done for one cycle.
//
// Optional feature: define USR_ABORT_EN to add the abort port, which cancels
// a running sequence without a final shift and without a done pulse.
//
// Command semantics: load and start are one-cycle requests sampled on a
// rising edge only while busy=0 (the block is idle). A request presented
// while busy=1 is dropped, not queued. done is a single-cycle pulse, and a
// new start may be presented in that same cycle.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
`ifdef USR_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   nxt_q;
    logic               nxt_so;

    // Debug view of the sequencer state (1 = shifting).
    assign state_dbg = (state == S_SHIFT);

    // One shift step in the latched mode; ser_in is taken live each edge.
    always_comb begin
        nxt_q  = q;
        nxt_so = ser_out;
        case (mode_q)
            MODE_SHL: begin
                nxt_q  = {q[WIDTH-2:0], ser_in};
                nxt_so = q[WIDTH-1];
            end
            MODE_SHR: begin
                nxt_q  = {ser_in, q[WIDTH-1:1]};
                nxt_so = q[0];
            end
            MODE_ROL: begin
                nxt_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                nxt_so = q[WIDTH-1];
            end
            MODE_ROR: begin
                nxt_q  = {q[0], q[WIDTH-1:1]};
                nxt_so = q[0];
            end
            default: begin
                nxt_q  = q;
                nxt_so = ser_out;
            end
        endcase
    end

    // Sequencer: idle accepts load/start, shift state counts down to done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            q       <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mode_q  <= MODE_SHL;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The load lands at this edge, so a same-cycle start
                    // shifts the freshly loaded value.
                    if (load) begin
                        q <= data_in;
                    end
                    if (start) begin
                        mode_q <= mode;
                        cnt    <= shift_cnt;
                        if (shift_cnt != '0) begin
                            state <= S_SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            // Zero-length sequence completes immediately.
                            done <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
`ifdef USR_ABORT_EN
                    if (abort) begin
                        // Cancel: no shift this edge, contents kept, no done.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else
`endif
                    begin
                        q       <= nxt_q;
                        ser_out <= nxt_so;
                        cnt     <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Testbench for shift_reg_univ (WIDTH=8, CNT_W=4). Expected results come from
// a bit-queue model of the register; a monitor pops them on every done pulse.
module tb_shift_reg_univ;

    localparam int W  = 8;
    localparam int CW = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          ser_in = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          start = 1'b0;
    logic [CW-1:0] shift_cnt = '0;
`ifdef USR_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;
    logic          state_dbg;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data_in   (data_in),
        .ser_in    (ser_in),
        .mode      (mode),
        .start     (start),
        .shift_cnt (shift_cnt),
`ifdef USR_ABORT_EN
        .abort     (abort),
`endif
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int           checks = 0;
    int           failures = 0;
    logic [W:0]   exp_q[$];      // {ser_out, q} expected at each done pulse
    logic [W-1:0] m_q = '0;      // model register
    logic         m_so = 1'b0;   // model ser_out
    logic         ser_bits[16];  // serial fill bit per shift of a sequence
    logic [W-1:0] trace_q[$];    // q observed after each shift edge

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: register as a queue of bits, element 0 = MSB.
    task automatic model_run(input logic [1:0] md, input int n);
        logic b[$];
        logic t;
        for (int i = W - 1; i >= 0; i--) b.push_back(m_q[i]);
        for (int i = 0; i < n; i++) begin
            case (md)
                2'b00: begin m_so = b.pop_front(); b.push_back(ser_bits[i]);  end
                2'b01: begin m_so = b.pop_back();  b.push_front(ser_bits[i]); end
                2'b10: begin t = b.pop_front(); m_so = t; b.push_back(t);     end
                default: begin t = b.pop_back(); m_so = t; b.push_front(t);   end
            endcase
        end
        for (int i = 0; i < W; i++) m_q[W-1-i] = b[i];
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [W:0] e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending sequence");
            end else begin
                e = exp_q.pop_front();
                check("done_q", 32'(q), 32'(e[W-1:0]));
                check("done_ser_out", 32'(ser_out), 32'(e[W]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.

    // ser_fix: 0/1 = constant fill bit, anything else = random fill bits.
    task automatic run_seq(input bit do_load, input logic [W-1:0] d, input logic [1:0] md,
                           input int n, input int ser_fix, input bit poke_busy);
        int busy_cnt;
        int got;
        for (int i = 0; i < 16; i++)
            ser_bits[i] = (ser_fix == 0 || ser_fix == 1) ? 1'(ser_fix) : 1'($urandom_range(0, 1));
        if (do_load) m_q = d;
        model_run(md, n);
        exp_q.push_back({m_so, m_q});

        load = do_load; data_in = d; mode = md; shift_cnt = CW'(n); start = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        data_in = W'($urandom); mode = 2'($urandom); shift_cnt = CW'($urandom);
        trace_q.delete();
        busy_cnt = 0;
        got = -1;
        for (int c = 0; c <= n + 3; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                trace_q.push_back(q);
            end
            if (c < n) ser_in = ser_bits[c];
            if (poke_busy && c == 1) begin
                load = 1'b1; data_in = '1; start = 1'b1; shift_cnt = CW'($urandom);
            end
            if (poke_busy && c == 2) begin
                load = 1'b0; start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                got = c;
                break;
            end
        end
        load = 1'b0; start = 1'b0;
        check("done_latency", 32'(got), 32'(n));
        check("busy_cycles", 32'(busy_cnt), 32'(n));
    endtask

    task automatic load_only(input logic [W-1:0] d);
        load = 1'b1; data_in = d;
        @(posedge clk); #1;
        load = 1'b0;
        m_q = d;
        check("load_q", 32'(q), 32'(d));
    endtask

    task automatic reset_mid_seq();
        load = 1'b1; data_in = W'($urandom); mode = 2'($urandom); shift_cnt = CW'(5); start = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        @(posedge clk); #1;          // first shift done
        #2 rst_n = 1'b0;             // lands before the second shift edge
        #1;
        check("rst_seq_q", 32'(q), 32'h0);
        check("rst_seq_busy", 32'(busy), 32'h0);
        check("rst_seq_done", 32'(done), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_q = '0; m_so = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_rst_no_done", 32'(done), 32'h0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        #1;
        check("reset_q", 32'(q), 32'h0);
        check("reset_ser_out", 32'(ser_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_state", 32'(state_dbg), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Shift left with ser_in=1 from 0xA5.
        run_seq(1'b1, 8'hA5, 2'b00, 3, 1, 1'b0);
        check("shl_step1", 32'(trace_q[0]), 32'h4B);
        check("shl_step2", 32'(trace_q[1]), 32'h97);
        check("shl_step3", 32'(trace_q[2]), 32'h2F);
        check("shl_ser_out", 32'(ser_out), 32'h1);

        // Load + start together, rotate right by 4 (back-to-back start).
        run_seq(1'b1, 8'h96, 2'b11, 4, 2, 1'b0);
        check("ror4_q", 32'(trace_q[3]), 32'h69);

        // Rotate left by a full width returns the original word.
        run_seq(1'b1, 8'h81, 2'b10, 8, 2, 1'b0);
        check("rol8_q", 32'(trace_q[7]), 32'h81);

        // N=0: immediate done, q unchanged.
        run_seq(1'b0, 8'h00, 2'b01, 0, 2, 1'b0);
        check("n0_q", 32'(q), 32'h81);

        // Load/start while busy are ignored.
        run_seq(1'b1, 8'h3C, 2'b01, 6, 2, 1'b1);

        // Asynchronous reset mid-cycle while idle.
        load_only(8'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 32'h0);
        check("async_rst_ser_out", 32'(ser_out), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_q = '0; m_so = 1'b0;

        // Reset during an N=5 sequence, then a normal sequence.
        reset_mid_seq();
        run_seq(1'b1, 8'hC3, 2'b00, 5, 2, 1'b0);

`ifdef USR_ABORT_EN
        // Abort after two right shifts of 0xF0 with ser_in=0.
        load = 1'b1; data_in = 8'hF0; mode = 2'b01; shift_cnt = CW'(6); start = 1'b1; ser_in = 1'b0;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_q", 32'(q), 32'h3C);
        check("abort_ser_out", 32'(ser_out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (8) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'h0);
        end
        m_q = 8'h3C; m_so = 1'b0;
`endif

        // Randomized sequences, with idle gaps and busy-time pokes.
        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    ser_in = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            run_seq(1'($urandom_range(0, 1)), W'($urandom), 2'($urandom_range(0, 3)), n, 2,
                    (n >= 3) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
